mul_seq16: RTL and testbench



---
 rtl/mul_seq16.sv | 121 ++++++++++++
 tb/tb_mul_seq16.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq16.sv
// mul_seq16: sequential shift-add multiplier producing the full 2*W-bit product.
// One start strobe launches a fixed W+1 cycle operation that ends in a one-cycle
// done pulse. Dalja holds the last product until the next operation completes.
// Optional build macro MUL_SIGNED_EN: treat operands as two's complement. Magnitudes
// are multiplied and the sign is applied when the result is written to Dalja.
module mul_seq16 #(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   Hyrja1,
  input  logic [W-1:0]   Hyrja2,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] Dalja
);

  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] dalja_q, dalja_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2*W-1:0] acc_sum;  // accumulator after this cycle's conditional add
  logic [2*W-1:0] result;   // value written to Dalja when the last step completes
  logic [W-1:0]   mag_a, mag_b;

  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
  assign mag_a  = Hyrja1[W-1] ? (~Hyrja1 + W'(1)) : Hyrja1;
  assign mag_b  = Hyrja2[W-1] ? (~Hyrja2 + W'(1)) : Hyrja2;
  assign result = neg_q ? (~acc_sum + (2*W)'(1)) : acc_sum;
`else
  assign mag_a  = Hyrja1;
  assign mag_b  = Hyrja2;
  assign result = acc_sum;
`endif

  // Next-state logic: accept in IDLE/DONE, one shift-add step per RUN cycle.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    dalja_d  = dalja_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef MUL_SIGNED_EN
    neg_d    = neg_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          mcand_d  = {{W{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = CntW'(W);
`ifdef MUL_SIGNED_EN
          neg_d    = Hyrja1[W-1] ^ Hyrja2[W-1];
`endif
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          dalja_d = result;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      dalja_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      dalja_q  <= dalja_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign Dalja = dalja_q;

endmodule

// File: tb/tb_mul_seq16.sv
// Self-checking bench for mul_seq16: vector table, hand-written handshake/reset
// sequences and randomized operands against an arithmetic reference model.
module tb_mul_seq16;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] dalja;

  int n_run = 0;
  int n_fail = 0;

  mul_seq16 #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .Hyrja1 (a_in),
    .Hyrja2 (b_in),
    .busy   (busy),
    .done   (done),
    .Dalja  (dalja)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_u;
    logic [31:0] exp_s;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product from plain wide arithmetic.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [63:0] p;
`ifdef MUL_SIGNED_EN
    p = {{48{a[15]}}, a} * {{48{b[15]}}, b};
`else
    p = {48'b0, a} * {48'b0, b};
`endif
    return p[31:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from an idle point and checks latency, result and hold.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input string name);
    logic        ok;
    logic [31:0] prev;
    ok   = 1'b1;
    prev = dalja;
    a_in = a;
    b_in = b;
    start = 1'b1;
    tick;
    start = 1'b0;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    for (int i = 1; i <= 16; i++) begin
      if (!(busy === 1'b1 && done === 1'b0 && dalja === prev)) ok = 1'b0;
      tick;
    end
    check({name, " busy window"}, 64'(ok), 64'd1);
    check({name, " done cycle"}, {62'b0, busy, done}, 64'b01);
    check({name, " Dalja"}, 64'(dalja), 64'(exp));
    tick;
    check({name, " after done"}, {30'b0, busy, done, dalja}, {32'b0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[6];
    logic        ok;
    logic [15:0] ra, rb;
    logic [31:0] e;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h00000001};
    vecs[2] = '{16'h0000, 16'hABCD, 32'h00000000, 32'h00000000};
    vecs[3] = '{16'hFFFD, 16'h0005, 32'h0004FFF1, 32'hFFFFFFF1};
    vecs[4] = '{16'h8000, 16'h8000, 32'h40000000, 32'h40000000};
    vecs[5] = '{16'h1234, 16'h0002, 32'h00002468, 32'h00002468};

    #2;
    check("reset outputs", {30'b0, busy, done, dalja}, 64'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) begin
`ifdef MUL_SIGNED_EN
      e = vecs[i].exp_s;
`else
      e = vecs[i].exp_u;
`endif
      run_op(vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
    end

    // Reset in the middle of RUN: outputs clear at once and no done follows.
    a_in = 16'h1234;
    b_in = 16'h0002;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    #3 rst_n = 1'b0;
    #1;
    check("async reset mid-run", {30'b0, busy, done, dalja}, 64'd0);
    #2 rst_n = 1'b1;
    tick;
    ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || dalja !== 32'd0) ok = 1'b0;
      tick;
    end
    check("quiet after reset", 64'(ok), 64'd1);

    // start held high through RUN with changing operands, then back-to-back start.
    a_in = 16'h0011;
    b_in = 16'h0003;
    start = 1'b1;
    tick;
    ok = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      tick;
    end
    check("held start busy", 64'(ok), 64'd1);
    check("held start done", {62'b0, busy, done}, 64'b01);
    check("held start Dalja", 64'(dalja), 64'(ref_mul(16'h0011, 16'h0003)));
    a_in = 16'd2;
    b_in = 16'd7;
    tick;
    start = 1'b0;
    check("no idle gap", {62'b0, busy, done}, 64'b10);
    ok = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (!(busy === 1'b1 && done === 1'b0 && dalja === ref_mul(16'h0011, 16'h0003))) ok = 1'b0;
      tick;
    end
    check("second run busy", 64'(ok), 64'd1);
    check("second done", {62'b0, busy, done}, 64'b01);
    check("second Dalja", 64'(dalja), 64'h0000000E);
    tick;

    // Randomized operands against the reference model.
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 5 == 0) rb = 16'h8000;
      run_op(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
